// File: rtl/cart_pkg.sv
// Shared types and constants for the cartridge dump sequencer.
// Holds state encodings, bank-select encodings and the checksum helper.
package cart_pkg;

   localparam int CART_ADDR_W = 14;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SETUP  = 3'd1,
      ST_SETTLE = 3'd2,
      ST_SAMPLE = 3'd3,
      ST_DONE   = 3'd4
   } state_e;

   typedef enum logic {
      BANK_S4 = 1'b0,
      BANK_S5 = 1'b1
   } bank_e;

   // Running checksum: byte zero-extended, sum wraps at 16 bits.
   function automatic logic [15:0] csum_add(input logic [15:0] sum, input logic [7:0] b);
      return sum + {8'h00, b};
   endfunction

endpackage

// File: rtl/cart_dump_seq_if.sv
// Output stream of {addr, data} pairs from the dump sequencer to its consumer.
interface cart_dump_seq_if
   import cart_pkg::*;
#(
   parameter int ADDR_W = CART_ADDR_W
) ();
   logic [ADDR_W-1:0] out_addr;
   logic [7:0]        out_data;
   logic              out_valid;
   logic              out_ready;

   modport master (output out_addr, output out_data, output out_valid, input out_ready);
   modport slave  (input out_addr, input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/cart_fifo.sv
// First-word-fall-through FIFO with registered full/empty flags.
// Pushes while full and pops while empty are dropped.
module cart_fifo #(
   parameter int WIDTH = 22,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);
   localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
   localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [PTR_W:0]   count_r;
   logic [PTR_W:0]   count_nxt_s;
   logic             full_r;
   logic             empty_r;
   logic             do_push_s;
   logic             do_pop_s;

   assign do_push_s = push & ~full_r;
   assign do_pop_s  = pop & ~empty_r;
   assign dout      = mem_r[rd_ptr_r];
   assign full      = full_r;
   assign empty     = empty_r;

   // Occupancy after this cycle's push/pop.
   always_comb begin
      count_nxt_s = count_r;
      case ({do_push_s, do_pop_s})
         2'b10:   count_nxt_s = count_r + CNT_ONE;
         2'b01:   count_nxt_s = count_r - CNT_ONE;
         default: count_nxt_s = count_r;
      endcase
   end

   // Storage, pointers and flags; storage is cleared so the head reads zero after reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= '0;
         end
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
         full_r   <= 1'b0;
         empty_r  <= 1'b1;
      end else begin
         if (do_push_s) begin
            mem_r[wr_ptr_r] <= din;
            wr_ptr_r        <= wr_ptr_r + PTR_ONE;
         end
         if (do_pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         count_r <= count_nxt_s;
         full_r  <= (count_nxt_s == CNT_FULL);
         empty_r <= (count_nxt_s == '0);
      end
   end
endmodule

// File: rtl/cart_dump_seq.sv
// Cartridge ROM dump sequencer: sweeps all addresses, waits a settle time,
// samples the synchronised data bus and streams {addr, data} through a FIFO.
module cart_dump_seq
   import cart_pkg::*;
#(
   parameter int ADDR_W     = CART_ADDR_W,
   parameter int SETTLE     = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                bank_sel,
   output logic [ADDR_W-1:0]   cart_addr,
   output logic                cart_s4,
   output logic                cart_s5,
   input  logic [7:0]          cart_data,
   cart_dump_seq_if.master     out_if,
   output logic                busy,
   output logic                done,
   output logic [15:0]         checksum
);
   localparam int                CNT_W     = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [CNT_W-1:0]  SETTLE_LD = CNT_W'(SETTLE - 1);
   localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
   localparam logic [ADDR_W-1:0] ADDR_MAX  = '1;
   localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

   state_e            state_r, state_nxt_s;
   bank_e             bank_r, bank_nxt_s;
   logic [ADDR_W-1:0] addr_r, addr_nxt_s;
   logic [CNT_W-1:0]  cnt_r, cnt_nxt_s;
   logic [15:0]       sum_r, sum_nxt_s;
   logic [7:0]        sync1_r, sync2_r;
   logic              busy_r, done_r, s4_r, s5_r;
   logic              busy_nxt_s;
   logic              push_s;
   logic              pop_s;
   logic              fifo_full_s;
   logic              fifo_empty_s;
   logic [ADDR_W+7:0] fifo_dout_s;

   assign cart_addr = addr_r;
   assign cart_s4   = s4_r;
   assign cart_s5   = s5_r;
   assign busy      = busy_r;
   assign done      = done_r;
   assign checksum  = sum_r;

   assign pop_s            = out_if.out_valid & out_if.out_ready;
   assign out_if.out_valid = ~fifo_empty_s;
   assign out_if.out_addr  = fifo_dout_s[ADDR_W+7:8];
   assign out_if.out_data  = fifo_dout_s[7:0];

   // Two-flop synchroniser for the asynchronous cartridge data bus.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_r <= 8'h00;
         sync2_r <= 8'h00;
      end else begin
         sync1_r <= cart_data;
         sync2_r <= sync1_r;
      end
   end

   // Sweep FSM next state; full test uses the FIFO's registered flag.
   always_comb begin
      state_nxt_s = state_r;
      bank_nxt_s  = bank_r;
      addr_nxt_s  = addr_r;
      cnt_nxt_s   = cnt_r;
      sum_nxt_s   = sum_r;
      push_s      = 1'b0;
      case (state_r)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               bank_nxt_s  = bank_e'(bank_sel);
               addr_nxt_s  = '0;
               sum_nxt_s   = 16'h0000;
               state_nxt_s = ST_SETUP;
            end else begin
               state_nxt_s = state_r;
            end
         end
         ST_SETUP: begin
            cnt_nxt_s   = SETTLE_LD;
            state_nxt_s = ST_SETTLE;
         end
         ST_SETTLE: begin
            if (cnt_r == '0) begin
               state_nxt_s = ST_SAMPLE;
            end else begin
               cnt_nxt_s = cnt_r - CNT_ONE;
            end
         end
         ST_SAMPLE: begin
            if (!fifo_full_s) begin
               push_s    = 1'b1;
               sum_nxt_s = csum_add(sum_r, sync2_r);
               if (addr_r == ADDR_MAX) begin
                  state_nxt_s = ST_DONE;
               end else begin
                  addr_nxt_s  = addr_r + ADDR_ONE;
                  state_nxt_s = ST_SETUP;
               end
            end else begin
               state_nxt_s = ST_SAMPLE;
            end
         end
         default: state_nxt_s = ST_IDLE;
      endcase
      busy_nxt_s = (state_nxt_s == ST_SETUP) || (state_nxt_s == ST_SETTLE) ||
                   (state_nxt_s == ST_SAMPLE);
   end

   // FSM/datapath registers; status and selects are registered from next-state values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_IDLE;
         bank_r  <= BANK_S4;
         addr_r  <= '0;
         cnt_r   <= '0;
         sum_r   <= 16'h0000;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         s4_r    <= 1'b0;
         s5_r    <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         bank_r  <= bank_nxt_s;
         addr_r  <= addr_nxt_s;
         cnt_r   <= cnt_nxt_s;
         sum_r   <= sum_nxt_s;
         busy_r  <= busy_nxt_s;
         done_r  <= (state_nxt_s == ST_DONE);
         s4_r    <= busy_nxt_s & (bank_nxt_s == BANK_S4);
         s5_r    <= busy_nxt_s & (bank_nxt_s == BANK_S5);
      end
   end

   cart_fifo #(
      .WIDTH (ADDR_W + 8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_s),
      .pop   (pop_s),
      .din   ({addr_r, sync2_r}),
      .dout  (fifo_dout_s),
      .full  (fifo_full_s),
      .empty (fifo_empty_s)
   );
endmodule

// File: tb/tb_cart_dump_seq.sv
// Bench for cart_dump_seq: table of sweep scenarios checked by a scoreboard,
// plus a hand-written mid-sweep reset sequence.
module tb_cart_dump_seq;
   localparam int AW = 4;
   localparam int ST = 3;
   localparam int FD = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          bank_sel;
   logic [AW-1:0] cart_addr;
   logic          cart_s4;
   logic          cart_s5;
   logic [7:0]    cart_data;
   logic          busy;
   logic          done;
   logic [15:0]   checksum;

   cart_dump_seq_if #(.ADDR_W(AW)) oif ();

   cart_dump_seq #(.ADDR_W(AW), .SETTLE(ST), .FIFO_DEPTH(FD)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .bank_sel  (bank_sel),
      .cart_addr (cart_addr),
      .cart_s4   (cart_s4),
      .cart_s5   (cart_s5),
      .cart_data (cart_data),
      .out_if    (oif),
      .busy      (busy),
      .done      (done),
      .checksum  (checksum)
   );

   always #5 clk = ~clk;

   // Cartridge model: data = addr ^ A5 two cycles after the address; in glitch
   // mode the bus only carries the right byte in the cycle the address is 2 cycles old.
   logic [AW-1:0] d1 = '0, d2 = '0, d3 = '0;
   logic [7:0]    noise = 8'h00;
   bit            glitch_en = 1'b0;

   always @(posedge clk) begin
      d1    <= cart_addr;
      d2    <= d1;
      d3    <= d2;
      noise <= 8'($urandom);
   end

   always_comb begin
      cart_data = {4'h0, d2} ^ 8'hA5;
      if (glitch_en && !((d2 == cart_addr) && (d3 != cart_addr))) cart_data = noise;
   end

   typedef struct packed {
      logic [AW-1:0] a;
      logic [7:0]    d;
   } ent_t;

   typedef struct {
      bit bank;
      bit stall;
      bit glitch;
      bit mid_start;
      int exp_cycles;
   } vec_t;

   ent_t exp_q[$];
   int   total = 0;
   int   bad = 0;
   bit   bank_exp = 1'b0;
   vec_t vecs[6];

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endfunction

   // Scoreboard: compare every accepted FIFO head and the bank selects each cycle.
   always @(negedge clk) begin
      if (rst === 1'b0) begin
         chk("sel_s4", cart_s4, busy & ~bank_exp);
         chk("sel_s5", cart_s5, busy & bank_exp);
         if (oif.out_valid && oif.out_ready) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_entry: got addr %0h data %0h, none expected",
                        oif.out_addr, oif.out_data);
            end else begin
               ent_t e;
               e = exp_q.pop_front();
               chk("out_addr", oif.out_addr, e.a);
               chk("out_data", oif.out_data, e.d);
            end
         end
      end
   end

   task automatic push_expected();
      for (int a = 0; a < (1 << AW); a++) begin
         ent_t e;
         e.a = a[AW-1:0];
         e.d = {4'h0, a[AW-1:0]} ^ 8'hA5;
         exp_q.push_back(e);
      end
   endtask

   task automatic pulse_start(input bit b);
      @(posedge clk);
      #1 start = 1'b1;
      bank_sel = b;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic run_sweep(input vec_t v);
      int cycles;
      int n;
      bit fired;
      bank_exp       = v.bank;
      glitch_en      = v.glitch;
      oif.out_ready  = !v.stall;
      push_expected();
      pulse_start(v.bank);
      cycles = 0;
      fired  = 1'b0;
      while (cycles < 400) begin
         @(negedge clk);
         if (done) break;
         cycles++;
         if (cycles == 1) chk("sum_cleared", checksum, 16'h0000);
         if (v.mid_start && !fired && cart_addr == 4'h7) begin
            start    = 1'b1;
            bank_sel = ~v.bank;
            fired    = 1'b1;
         end else begin
            start = 1'b0;
         end
         if (v.stall && (cycles == 40 || cycles == 60)) begin
            chk("stall_addr", cart_addr, 4'h4);
            chk("stall_busy", busy, 1'b1);
            chk("stall_valid", oif.out_valid, 1'b1);
         end
         if (v.stall && cycles == 60) begin
            @(posedge clk);
            #1 oif.out_ready = 1'b1;
         end
      end
      start = 1'b0;
      chk("done_seen", done, 1'b1);
      if (v.exp_cycles > 0) chk("sweep_cycles", cycles, v.exp_cycles);
      chk("checksum", checksum, 16'h0A78);
      chk("busy_end", busy, 1'b0);
      chk("s4_end", cart_s4, 1'b0);
      chk("s5_end", cart_s5, 1'b0);
      chk("addr_hold", cart_addr, 4'hF);
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      chk("drained", exp_q.size(), 0);
      chk("valid_low", oif.out_valid, 1'b0);
      glitch_en = 1'b0;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int n;
      vecs[0] = '{bank: 1'b0, stall: 1'b0, glitch: 1'b0, mid_start: 1'b0, exp_cycles: 80};
      vecs[1] = '{bank: 1'b1, stall: 1'b0, glitch: 1'b0, mid_start: 1'b0, exp_cycles: 80};
      vecs[2] = '{bank: 1'b0, stall: 1'b1, glitch: 1'b0, mid_start: 1'b0, exp_cycles: -1};
      vecs[3] = '{bank: 1'b1, stall: 1'b0, glitch: 1'b0, mid_start: 1'b1, exp_cycles: 80};
      vecs[4] = '{bank: 1'b0, stall: 1'b0, glitch: 1'b0, mid_start: 1'b0, exp_cycles: 80};
      vecs[5] = '{bank: 1'b0, stall: 1'b0, glitch: 1'b1, mid_start: 1'b0, exp_cycles: 80};

      rst           = 1'b1;
      start         = 1'b0;
      bank_sel      = 1'b0;
      oif.out_ready = 1'b1;
      #12;
      chk("rst_addr", cart_addr, 4'h0);
      chk("rst_s4", cart_s4, 1'b0);
      chk("rst_s5", cart_s5, 1'b0);
      chk("rst_valid", oif.out_valid, 1'b0);
      chk("rst_out_addr", oif.out_addr, 4'h0);
      chk("rst_out_data", oif.out_data, 8'h00);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_sum", checksum, 16'h0000);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 6; i++) begin
         run_sweep(vecs[i]);
      end

      // Reset in SETTLE at address 9, then a clean sweep from address 0.
      bank_exp      = 1'b0;
      oif.out_ready = 1'b1;
      push_expected();
      pulse_start(1'b0);
      n = 0;
      while (cart_addr != 4'h9 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("reach_addr9", cart_addr, 4'h9);
      @(negedge clk);
      chk("pre_rst_busy", busy, 1'b1);
      chk("pre_rst_s4", cart_s4, 1'b1);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_busy", busy, 1'b0);
      chk("mid_rst_s4", cart_s4, 1'b0);
      chk("mid_rst_s5", cart_s5, 1'b0);
      chk("mid_rst_valid", oif.out_valid, 1'b0);
      chk("mid_rst_sum", checksum, 16'h0000);
      chk("mid_rst_addr", cart_addr, 4'h0);
      exp_q.delete();
      @(negedge clk);
      #2 rst = 1'b0;
      run_sweep(vecs[0]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/cart_dump_seq.md
Name: cart_dump_seq

Overview:
- Automatic cartridge read sequencer that replaces manual address stepping for cartridge ROM bring-up.
- Sweeps the full cartridge address space and drives the address and the two bank-select lines (S4/S5) to the cartridge header.
- After a programmable settle time it samples the 8-bit data bus through a synchroniser.
- Streams {addr, data} pairs through a small FIFO with a valid/ready handshake to a downstream consumer (ChipScope/UART dumper) and accumulates a 16-bit checksum.

Parameters:
- ADDR_W, 14, cartridge address width; sweep covers 0..2^ADDR_W-1.
- SETTLE, 8, clk cycles between address/select change and data sample (≥1).
- FIFO_DEPTH, 4, output FIFO entries (power of 2, ≥2).

Ports:
- clk  in  1  system clock (divided board clock).
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a sweep when idle.
- bank_sel  in  1  latched at start; 0 selects S4, 1 selects S5.
- cart_addr  out  ADDR_W  address to cartridge header.
- cart_s4  out  1  active-high bank select, low bank.
- cart_s5  out  1  active-high bank select, high bank.
- cart_data  in  8  asynchronous cartridge data bus.
- out_addr  out  ADDR_W  address of FIFO head entry.
- out_data  out  8  data of FIFO head entry.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts head when out_valid & out_ready.
- busy  out  1  sweep in progress.
- done  out  1  sweep complete; held until next accepted start or rst.
- checksum  out  16  sum of all sampled bytes, modulo 2^16.

Behaviour:
- Reset (async, immediate): state IDLE; cart_addr=0; cart_s4=cart_s5=0; FIFO empty, so out_valid=0; out_addr=0 and out_data=0; busy=0; done=0; checksum=0; synchroniser flops=0.
- cart_data passes through a 2-flop synchroniser every cycle; only the second-stage value is sampled.
- FSM states: IDLE, SETUP, SETTLE, SAMPLE, DONE.
- IDLE: start=1 → latch bank_sel, cart_addr=0, checksum=0, done=0 → SETUP.
- SETUP: 1 cycle; address and select are stable on outputs; load settle counter with SETTLE-1 → SETTLE.
- SETTLE: decrement counter each cycle; when counter=0 → SAMPLE. Dwell is exactly SETTLE cycles.
- SAMPLE with FIFO not full:
  - push {cart_addr, sync_data}; checksum += sync_data, zero-extended, wrap at 16 bits.
  - If cart_addr = 2^ADDR_W-1 → DONE; else cart_addr+1 → SETUP.
- SAMPLE with FIFO full: stay in SAMPLE. No push, no checksum update, address and selects held. Re-sample each cycle until there is space; the pushed byte is the sync value in the cycle of the push.
- DONE: busy=0, done=1, selects deasserted, cart_addr holds last address. start → restart, same as from IDLE.
- Steady-state throughput, FIFO never full: one byte every SETTLE+2 cycles.
- busy=1 in SETUP, SETTLE and SAMPLE.
- cart_s4 = busy & ~bank_q; cart_s5 = busy & bank_q. Never both high; both low outside a sweep.
- start while busy: ignored. bank_sel changes mid-sweep: ignored.
- FIFO:
  - Synchronous, first-word-fall-through: out_addr/out_data show the head whenever out_valid=1.
  - Push and pop in the same cycle when full: pop frees the entry, but the sequencer's full test uses the registered full flag, so the push waits one cycle.
  - Push on empty: out_valid rises the next cycle.
- FIFO contents persist after DONE until drained. A new start does not flush the FIFO; the new sweep's entries append.
- rst mid-sweep: FSM, FIFO, checksum and outputs clear immediately; selects drop asynchronously.

Decomposition:
- Shared package cart_pkg: state encoding constants (IDLE, SETUP, SETTLE, SAMPLE, DONE); CART_ADDR_W=14; bank select encodings (BANK_S4=0, BANK_S5=1).
- One sub-module: cart_fifo, a parameterised FWFT FIFO (width ADDR_W+8, depth FIFO_DEPTH, async active-high rst, push/pop/full/empty).
- Synchroniser and FSM stay inline.

Test Plan:
- Bench setup: ADDR_W=4, SETTLE=3, FIFO_DEPTH=4. Cartridge model returns addr^8'hA5 after a 2-cycle delay.
- Full sweep, bank_sel=0, out_ready=1 → 16 entries (0,A5),(1,A4)…(F,AA) in order; checksum=16'h0A78; done=1 after 16×5 cycles plus pipeline; cart_s5 never high.
- bank_sel=1 sweep → only cart_s5 high while busy, cart_s4=0 throughout; same data and checksum.
- out_ready=0 for the whole sweep → sequencer stalls in SAMPLE at addr 4 with 4 entries queued. Raise out_ready → sweep resumes, no loss or duplication, checksum still 16'h0A78.
- start pulsed again at addr 7 mid-sweep → ignored; sweep ends with exactly 16 entries; a subsequent start after DONE clears done and checksum and sweeps again.
- rst asserted while in SETTLE at addr 9 → same-cycle: busy=0, selects=0, out_valid=0, checksum=0. Next start restarts from addr 0.
- Cartridge data changing during SETTLE (model glitches until the final cycle) → the sampled value is the 2-flop synchronised value at SAMPLE, matching the model value held ≥2 cycles before the sample.
